// File: rtl/cache_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// cache_fill_ctrl : cache line-fill sequencer owning the tag and valid stores
// Rev 1.0
//==============================================================================
module cache_fill_ctrl #(
  parameter int TAG_W  = 4,
  parameter int IDX_W  = 2,
  parameter int WORDS  = 4,
  parameter int DATA_W = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 miss_valid,
  input  logic [TAG_W-1:0]                     miss_tag,
  input  logic [IDX_W-1:0]                     miss_idx,
  output logic                                 miss_ready,
  input  logic                                 flush,
  input  logic [IDX_W-1:0]                     lk_idx,
  output logic                                 lk_valid,
  output logic [TAG_W-1:0]                     lk_tag,
  output logic                                 mem_req,
  output logic [TAG_W+IDX_W+$clog2(WORDS)-1:0] mem_addr,
  input  logic                                 mem_ack,
  input  logic                                 mem_rvalid,
  input  logic [DATA_W-1:0]                    mem_rdata,
  output logic                                 wr_en,
  output logic [IDX_W-1:0]                     wr_idx,
  output logic [$clog2(WORDS)-1:0]             wr_word,
  output logic [DATA_W-1:0]                    wr_data,
  output logic                                 fill_done
);

  localparam int WW    = $clog2(WORDS);
  localparam int LINES = 1 << IDX_W;
  localparam logic [WW-1:0] c_word_last = WW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_TAGWR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [WW-1:0]      r_word;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tags [LINES];

  logic w_idle;
  logic w_wait_data;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wait_data = (r_state == S_WAIT) && mem_rvalid;

  // Flush has priority over a miss arriving in the same IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_word  <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (miss_valid) begin
            r_tag             <= miss_tag;
            r_idx             <= miss_idx;
            r_word            <= '0;
            r_valid[miss_idx] <= 1'b0;
            r_state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (r_word == c_word_last) begin
              r_state <= S_TAGWR;
            end else begin
              r_word  <= r_word + 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_TAGWR: begin
          r_tags[r_idx]  <= r_tag;
          r_valid[r_idx] <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset gating keeps the handshake outputs quiet while reset is held.
  assign miss_ready = w_idle && !flush && !reset;
  assign mem_req    = (r_state == S_REQ) && !reset;
  assign mem_addr   = {r_tag, r_idx, r_word};
  assign wr_en      = w_wait_data && !reset;
  assign wr_idx     = r_idx;
  assign wr_word    = r_word;
  assign wr_data    = mem_rdata;
  assign fill_done  = (r_state == S_DONE) && !reset;
  assign lk_valid   = r_valid[lk_idx] && !reset;
  assign lk_tag     = r_tags[lk_idx];

endmodule
`default_nettype wire

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter TAG_W, default 4, tag width in bits.
REQ-002 Parameter IDX_W, default 2, line index width; the tag store SHALL hold 2**IDX_W lines.
REQ-003 Parameter WORDS, default 4, words per line (power of two, >=2).
REQ-004 Parameter DATA_W, default 8, data word width.
REQ-005 Ports SHALL be:
- clk  in  1  clock; single clock domain, all state on its rising edge.
- reset  in  1  synchronous, active-high.
- miss_valid  in  1  miss request.
- miss_tag  in  TAG_W  tag of the missing line.
- miss_idx  in  IDX_W  index of the missing line.
- miss_ready  out  1  request accepted when miss_valid&&miss_ready.
- flush  in  1  invalidate all lines.
- lk_idx  in  IDX_W  lookup index.
- lk_valid  out  1  valid bit of line lk_idx.
- lk_tag  out  TAG_W  stored tag of line lk_idx.
- mem_req  out  1  memory read request.
- mem_addr  out  TAG_W+IDX_W+log2(WORDS)  word address {tag,idx,word}.
- mem_ack  in  1  request accepted by memory.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- wr_en  out  1  data-array write strobe.
- wr_idx  out  IDX_W  data-array line.
- wr_word  out  log2(WORDS)  data-array word.
- wr_data  out  DATA_W  data-array write data.
- fill_done  out  1  one-cycle fill completion pulse.

Function
REQ-006 The block SHALL own a tag array and a valid-bit array of 2**IDX_W entries; lk_valid/lk_tag SHALL be combinational reads of entry lk_idx.
REQ-007 FSM states SHALL be IDLE, REQ, WAIT, TAGWR, DONE.
REQ-008 IDLE: miss_ready=1 iff !flush; flush SHALL clear all valid bits on the next edge and SHALL win over a simultaneous miss_valid (miss not accepted).
REQ-009 IDLE, miss_valid&&miss_ready: latch tag/idx, word counter=0, clear valid[miss_idx] on the same edge, go REQ.
REQ-010 REQ: mem_req=1, mem_addr={latched tag, latched idx, word}; hold stable until mem_ack; on mem_ack go WAIT.
REQ-011 WAIT: mem_req=0; on mem_rvalid drive wr_en=1 (same cycle, combinational), wr_idx=latched idx, wr_word=word, wr_data=mem_rdata; if word==WORDS-1 go TAGWR, else word+1 and go REQ.
REQ-012 TAGWR: write latched tag into tag[idx] and set valid[idx]=1 on this edge; go DONE.
REQ-013 DONE: fill_done=1 for exactly one cycle; go IDLE.
REQ-014 Fill latency with mem_ack and mem_rvalid each arriving on the first eligible cycle: acceptance to fill_done = 2*WORDS+2 cycles.
REQ-015 miss_ready=0 in all states except IDLE; miss_valid outside IDLE SHALL be ignored.
REQ-016 flush outside IDLE SHALL be ignored.
REQ-017 mem_rvalid outside WAIT and mem_ack outside REQ SHALL be ignored.
REQ-018 wr_en, mem_req, fill_done SHALL be 0 in every state other than the one defining them.
REQ-019 Word counter SHALL be log2(WORDS) bits and SHALL never wrap inside a fill.
REQ-020 lk_valid for the index being filled SHALL read 0 from the cycle after acceptance until the cycle after TAGWR.

Reset
REQ-021 reset SHALL, on the clock edge, force IDLE, clear all valid bits, clear word counter and latched tag/idx; tag array contents need not be cleared.
REQ-022 While reset is high, outputs: miss_ready=0, mem_req=0, wr_en=0, fill_done=0, lk_valid=0.
REQ-023 Reset asserted mid-fill SHALL abort the fill with no tag write and no fill_done.

Verification
REQ-024 Reset, lk_idx=0..3 -> lk_valid=0 all; miss_ready=1 after release.
REQ-025 Miss tag=0xA idx=2, mem acks immediately, rdata 0x11,0x22,0x33,0x44 -> mem_addr 0xA8..0xAB, wr_word 0..3 with that data, fill_done 10 cycles after accept, lk_idx=2 gives lk_valid=1 lk_tag=0xA.
REQ-026 Same miss with mem_ack delayed 3 cycles per word -> mem_req/mem_addr held stable, identical writes, fill_done at 22 cycles.
REQ-027 miss_valid and flush together in IDLE with line 1 valid -> no acceptance, all lk_valid=0 next cycle.
REQ-028 Reset after 2nd word write of fill to idx=3 -> no fill_done, lk_valid[3]=0, next miss accepted normally.
REQ-029 Stray mem_rvalid in IDLE/REQ and miss_valid during WAIT -> no wr_en, no second acceptance.
